// File: rtl/dut_event_toggle_counter_if.sv
// Control/status bundle for dut_event_toggle_counter; last_ts exists only when EVENT_TIMESTAMP_EN is defined.
interface dut_event_toggle_counter_if #(
   parameter int NUM_CH    = 2,
   parameter int CNT_WIDTH = 16,
   parameter int WIN_WIDTH = 24
);
   logic [NUM_CH-1:0]           ch_enable;
   logic                        edge_mode;
   logic [WIN_WIDTH-1:0]        win_len;
   logic                        start;
   logic                        stop;
   logic                        busy;
   logic                        done;
   logic [NUM_CH*CNT_WIDTH-1:0] cnt_snapshot;
   logic [NUM_CH-1:0]           ovf_snapshot;
`ifdef EVENT_TIMESTAMP_EN
   logic [NUM_CH*WIN_WIDTH-1:0] last_ts;

   modport master (
      output ch_enable, edge_mode, win_len, start, stop,
      input  busy, done, cnt_snapshot, ovf_snapshot, last_ts
   );
   modport slave (
      input  ch_enable, edge_mode, win_len, start, stop,
      output busy, done, cnt_snapshot, ovf_snapshot, last_ts
   );
`else
   modport master (
      output ch_enable, edge_mode, win_len, start, stop,
      input  busy, done, cnt_snapshot, ovf_snapshot
   );
   modport slave (
      input  ch_enable, edge_mode, win_len, start, stop,
      output busy, done, cnt_snapshot, ovf_snapshot
   );
`endif
endinterface

// File: rtl/dut_event_toggle_counter.sv
// Gated multi-channel event counter for toggle-encoded DUT event pins with coherent snapshot.
// Optional per-channel last-event timestamp enabled by defining EVENT_TIMESTAMP_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no window open; counters hold, snapshot shows last window
// ST_COUNT | window open; enabled events counted, timer advancing
// ST_LATCH | one cycle; counters copied to snapshot, done set
module dut_event_toggle_counter #(
   parameter int NUM_CH      = 2,
   parameter int CNT_WIDTH   = 16,
   parameter int WIN_WIDTH   = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic              S_AXI_ACLK,
   input  logic              S_AXI_ARESETN,
   input  logic [NUM_CH-1:0] event_toggle,
   output logic [NUM_CH-1:0] event_pulse,
   dut_event_toggle_counter_if.slave ctl
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_COUNT = 2'd1;
   localparam logic [1:0] ST_LATCH = 2'd2;

   logic [1:0]                  state;
   logic [NUM_CH-1:0]           sync_q [SYNC_STAGES];
   logic [NUM_CH-1:0]           hist_q;
   logic [NUM_CH-1:0]           det;
   logic [CNT_WIDTH-1:0]        cnt_q [NUM_CH];
   logic [NUM_CH-1:0]           ovf_q;
   logic [WIN_WIDTH-1:0]        timer_q;
   logic [WIN_WIDTH-1:0]        win_q;
   logic                        done_q;
   logic [NUM_CH*CNT_WIDTH-1:0] cnt_snap_q;
   logic [NUM_CH-1:0]           ovf_snap_q;
   logic                        restart;
   logic                        window_end;
`ifdef EVENT_TIMESTAMP_EN
   logic [WIN_WIDTH-1:0]        ts_q [NUM_CH];
   logic [NUM_CH*WIN_WIDTH-1:0] ts_snap_q;
`endif

   assign det = ctl.edge_mode ? (sync_q[SYNC_STAGES-1] & ~hist_q)
                              : (sync_q[SYNC_STAGES-1] ^ hist_q);

   // a start in LATCH is dropped so the snapshot of the closing window is never lost
   assign restart    = ctl.start && (state != ST_LATCH);
   assign window_end = ((win_q != '0) && (timer_q == (win_q - WIN_WIDTH'(1)))) || ctl.stop;

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         hist_q      <= '0;
         event_pulse <= '0;
         state       <= ST_IDLE;
         timer_q     <= '0;
         win_q       <= '0;
         done_q      <= 1'b0;
         ovf_q       <= '0;
         cnt_snap_q  <= '0;
         ovf_snap_q  <= '0;
         for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
`ifdef EVENT_TIMESTAMP_EN
         for (int k = 0; k < NUM_CH; k++) ts_q[k] <= '0;
         ts_snap_q <= '0;
`endif
      end else begin
         sync_q[0] <= event_toggle;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         hist_q      <= sync_q[SYNC_STAGES-1];
         event_pulse <= det;

         if (restart) begin
            state   <= ST_COUNT;
            timer_q <= '0;
            win_q   <= ctl.win_len;
            ovf_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
`ifdef EVENT_TIMESTAMP_EN
            for (int k = 0; k < NUM_CH; k++) ts_q[k] <= '0;
`endif
            if (state == ST_IDLE) done_q <= 1'b0;
         end else begin
            case (state)
               ST_COUNT: begin
                  timer_q <= timer_q + WIN_WIDTH'(1);
                  for (int k = 0; k < NUM_CH; k++) begin
                     if (event_pulse[k] && ctl.ch_enable[k]) begin
                        if (cnt_q[k] == '1) ovf_q[k] <= 1'b1;
                        else                cnt_q[k] <= cnt_q[k] + CNT_WIDTH'(1);
`ifdef EVENT_TIMESTAMP_EN
                        ts_q[k] <= timer_q;
`endif
                     end
                  end
                  if (window_end) state <= ST_LATCH;
               end
               ST_LATCH: begin
                  for (int k = 0; k < NUM_CH; k++)
                     cnt_snap_q[k*CNT_WIDTH +: CNT_WIDTH] <= cnt_q[k];
                  ovf_snap_q <= ovf_q;
`ifdef EVENT_TIMESTAMP_EN
                  for (int k = 0; k < NUM_CH; k++)
                     ts_snap_q[k*WIN_WIDTH +: WIN_WIDTH] <= ts_q[k];
`endif
                  done_q <= 1'b1;
                  state  <= ST_IDLE;
               end
               ST_IDLE: state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign ctl.busy         = (state == ST_COUNT);
   assign ctl.done         = done_q;
   assign ctl.cnt_snapshot = cnt_snap_q;
   assign ctl.ovf_snapshot = ovf_snap_q;
`ifdef EVENT_TIMESTAMP_EN
   assign ctl.last_ts      = ts_snap_q;
`endif

endmodule

// File: tb/tb_dut_event_toggle_counter.sv
// Self-checking bench for dut_event_toggle_counter (2 channels, 8-bit counters).
`timescale 1ns/1ps
module tb_dut_event_toggle_counter;
   localparam int NCH = 2;
   localparam int CW  = 8;
   localparam int WW  = 24;
   localparam int SS  = 2;

   typedef struct packed {
      logic [CW-1:0]  c1;
      logic [CW-1:0]  c0;
      logic [NCH-1:0] ovf;
   } snap_t;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic [NCH-1:0] tog   = '0;
   logic [NCH-1:0] ep;
   int             checks = 0;
   int             errors = 0;
   int             busy_cycles = 0;
   int             pulse_cnt [NCH] = '{0, 0};
   snap_t          sb [$];

   always #5 clk = ~clk;

   dut_event_toggle_counter_if #(.NUM_CH(NCH), .CNT_WIDTH(CW), .WIN_WIDTH(WW)) bus ();

   dut_event_toggle_counter #(
      .NUM_CH(NCH), .CNT_WIDTH(CW), .WIN_WIDTH(WW), .SYNC_STAGES(SS)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .event_toggle  (tog),
      .event_pulse   (ep),
      .ctl           (bus)
   );

   always @(negedge clk) begin
      if (bus.busy === 1'b1) busy_cycles = busy_cycles + 1;
      for (int k = 0; k < NCH; k++)
         if (ep[k] === 1'b1) pulse_cnt[k] = pulse_cnt[k] + 1;
   end

   function automatic snap_t cur_snap();
      snap_t s;
      s.c1  = bus.cnt_snapshot[2*CW-1:CW];
      s.c0  = bus.cnt_snapshot[CW-1:0];
      s.ovf = bus.ovf_snapshot;
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_start(input bit with_stop);
      bus.start = 1'b1;
      bus.stop  = with_stop;
      tick();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
   endtask

   task automatic toggles(input int ch, input int n);
      for (int i = 0; i < n; i++) begin
         tog[ch] = ~tog[ch];
         ticks(2);
      end
   endtask

   task automatic wait_done(output bit ok);
      int n = 0;
      while (bus.done !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      ok = (bus.done === 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ticks(3);
      rst_n = 1'b1;
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.cnt_snapshot !== '0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", bus.cnt_snapshot); end
      checks++; if (bus.ovf_snapshot !== '0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf_snapshot); end
      checks++; if (ep !== '0) begin errors++; $display("FAIL reset_pulse got=%b exp=0", ep); end
   endtask

   task automatic test_basic();
      snap_t e, g;
      bit ok;
      int b0;
      bus.ch_enable = 2'b11; bus.edge_mode = 1'b0; bus.win_len = 24'd100;
      e = '{c1: 8'd4, c0: 8'd10, ovf: 2'b00};
      sb.push_back(e);
      b0 = busy_cycles;
      pulse_start(1'b0);
      for (int i = 0; i < 10; i++) begin
         tog[0] = ~tog[0];
         if (i < 4) tog[1] = ~tog[1];
         ticks(2);
      end
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_done got=%b exp=1", bus.done); end
      checks++; if (busy_cycles - b0 != 100) begin errors++; $display("FAIL basic_busy_len got=%0d exp=100", busy_cycles - b0); end
      e = sb.pop_front(); g = cur_snap();
      checks++; if (g !== e) begin errors++; $display("FAIL basic_snap got=%h exp=%h", g, e); end
   endtask

   task automatic test_edge_mode();
      snap_t e, g;
      bit ok;
      bus.edge_mode = 1'b1; bus.win_len = 24'd100;
      e = '{c1: 8'd0, c0: 8'd5, ovf: 2'b00};
      sb.push_back(e);
      pulse_start(1'b0);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL edge_done_clear got=%b exp=0", bus.done); end
      toggles(0, 10);
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL edge_done got=%b exp=1", bus.done); end
      e = sb.pop_front(); g = cur_snap();
      checks++; if (g !== e) begin errors++; $display("FAIL edge_snap got=%h exp=%h", g, e); end
      bus.edge_mode = 1'b0;
   endtask

   task automatic test_enable();
      snap_t e, g;
      bit ok;
      int p0;
      bus.ch_enable = 2'b01; bus.win_len = 24'd100;
      e = '{c1: 8'd0, c0: 8'd0, ovf: 2'b00};
      sb.push_back(e);
      p0 = pulse_cnt[1];
      pulse_start(1'b0);
      toggles(1, 6);
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL enable_done got=%b exp=1", bus.done); end
      checks++; if (pulse_cnt[1] - p0 != 6) begin errors++; $display("FAIL enable_pulses got=%0d exp=6", pulse_cnt[1] - p0); end
      e = sb.pop_front(); g = cur_snap();
      checks++; if (g !== e) begin errors++; $display("FAIL enable_snap got=%h exp=%h", g, e); end
      bus.ch_enable = 2'b11;
   endtask

   task automatic test_saturation();
      snap_t e, g;
      bus.win_len = 24'd0;
      e = '{c1: 8'd0, c0: 8'd255, ovf: 2'b01};
      sb.push_back(e);
      pulse_start(1'b0);
      toggles(0, 300);
      ticks(6);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL sat_open_window got=%b exp=1", bus.busy); end
      pulse_stop();
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL sat_latch_cycle got busy=%b done=%b exp busy=0 done=0", bus.busy, bus.done); end
      tick();
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL sat_done got=%b exp=1", bus.done); end
      e = sb.pop_front(); g = cur_snap();
      checks++; if (g !== e) begin errors++; $display("FAIL sat_snap got=%h exp=%h", g, e); end
   endtask

   task automatic test_boundary();
      snap_t e, g;
      bus.win_len = 24'd20;
      e = '{c1: 8'd0, c0: 8'd1, ovf: 2'b00};
      sb.push_back(e);
      pulse_start(1'b1);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bound_start_wins got=%b exp=1", bus.busy); end
      ticks(16);
      tog[0] = ~tog[0];
      tick();
      tog[1] = ~tog[1];
      ticks(2);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bound_last_count got=%b exp=1", bus.busy); end
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bound_latch got=%b exp=0", bus.busy); end
      tick();
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL bound_done got=%b exp=1", bus.done); end
      e = sb.pop_front(); g = cur_snap();
      checks++; if (g !== e) begin errors++; $display("FAIL bound_snap got=%h exp=%h", g, e); end
   endtask

   task automatic test_restart();
      snap_t e, g, prev;
      bit ok;
      prev = '{c1: 8'd0, c0: 8'd1, ovf: 2'b00};
      bus.win_len = 24'd0;
      pulse_start(1'b0);
      toggles(0, 7);
      ticks(5);
      e = '{c1: 8'd0, c0: 8'd3, ovf: 2'b00};
      sb.push_back(e);
      pulse_start(1'b0);
      ticks(3);
      checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL restart_state got busy=%b done=%b exp busy=1 done=0", bus.busy, bus.done); end
      g = cur_snap();
      checks++; if (g !== prev) begin errors++; $display("FAIL restart_no_latch got=%h exp=%h", g, prev); end
      toggles(0, 3);
      ticks(5);
      pulse_stop();
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL restart_done got=%b exp=1", bus.done); end
      e = sb.pop_front(); g = cur_snap();
      checks++; if (g !== e) begin errors++; $display("FAIL restart_snap got=%h exp=%h", g, e); end
   endtask

`ifdef EVENT_TIMESTAMP_EN
   task automatic test_timestamp();
      bit ok;
      bus.win_len = 24'd60;
      pulse_start(1'b0);
      ticks(39);
      tog[0] = ~tog[0];
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL ts_done got=%b exp=1", bus.done); end
      checks++; if (bus.last_ts[WW-1:0] !== 24'd42) begin errors++; $display("FAIL ts_ch0 got=%0d exp=42", bus.last_ts[WW-1:0]); end
      checks++; if (bus.last_ts[2*WW-1:WW] !== 24'd0) begin errors++; $display("FAIL ts_ch1 got=%0d exp=0", bus.last_ts[2*WW-1:WW]); end
   endtask
`endif

   task automatic test_reset_mid_window();
      bus.win_len = 24'd0;
      pulse_start(1'b0);
      toggles(0, 3);
      ticks(4);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
      checks++; if (bus.cnt_snapshot !== '0) begin errors++; $display("FAIL midrst_cnt got=%h exp=0", bus.cnt_snapshot); end
      ticks(10);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_no_latch got=%b exp=0", bus.done); end
      checks++; if (bus.cnt_snapshot !== '0 || bus.ovf_snapshot !== '0) begin errors++; $display("FAIL midrst_snap got=%h/%b exp=0/0", bus.cnt_snapshot, bus.ovf_snapshot); end
   endtask

   initial begin
      bus.ch_enable = 2'b11;
      bus.edge_mode = 1'b0;
      bus.win_len   = '0;
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      test_reset();
      test_basic();
      test_edge_mode();
      test_enable();
      test_saturation();
      test_boundary();
      test_restart();
`ifdef EVENT_TIMESTAMP_EN
      test_timestamp();
`endif
      test_reset_mid_window();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dut_event_toggle_counter.md
Name: dut_event_toggle_counter

Overview:
Multi-channel event counter for DUT toggle-encoded event outputs, such as the up/down event toggle pins. It synchronises each toggle input into the AXI clock domain and detects transitions. Over a programmable gate window it counts events per channel, then latches all counts into a coherent snapshot for AXI readback. It sits inside fw_top between the DUT-side pins and the register bank, replacing the constant tie-off of the event toggle inputs.

Parameters:
NUM_CH, 2, number of event toggle channels (1..16)
CNT_WIDTH, 16, per-channel counter width (8..32)
WIN_WIDTH, 24, width of gate window length in S_AXI_ACLK cycles
SYNC_STAGES, 2, flip-flop synchroniser depth per input (>=2)

Ports:
S_AXI_ACLK  in  1  single clock for the whole block
S_AXI_ARESETN  in  1  synchronous active-low reset
event_toggle  in  NUM_CH  asynchronous DUT toggle inputs; each transition is one event
ch_enable  in  NUM_CH  per-channel count enable; sampled every cycle
edge_mode  in  1  0: count both edges; 1: count rising edges only
win_len  in  WIN_WIDTH  gate length in cycles; 0 means run until stop
start  in  1  one-cycle pulse; opens a new window
stop  in  1  one-cycle pulse; closes the window early
busy  out  1  high while a window is open
done  out  1  sticky; set on snapshot latch, cleared by the next start
cnt_snapshot  out  NUM_CH*CNT_WIDTH  latched counts; channel k at bits [k*CNT_WIDTH +: CNT_WIDTH]
ovf_snapshot  out  NUM_CH  latched per-channel saturation flags
event_pulse  out  NUM_CH  one-cycle pulse per detected event, for debug/ILA

Behaviour:
- Reset (S_AXI_ARESETN=0 at a clock edge):
  - synchronisers, edge registers, counters and window timer cleared; state=IDLE
  - outputs busy=0, done=0, cnt_snapshot=0, ovf_snapshot=0, event_pulse=0
  - reset mid-window aborts the window without a latch.
- Synchroniser: SYNC_STAGES flops, then one history flop.
  - event detected when the last stage differs from the history flop (edge_mode=0), or when last=1 and history=0 (edge_mode=1)
  - latency from pin transition to event_pulse: SYNC_STAGES+1 cycles.
- event_pulse is asserted in every state, independent of ch_enable.
- States:
  - IDLE: busy=0; counters hold. start -> COUNT: counters, overflow flags and timer cleared; done cleared; busy=1 from the next cycle.
  - COUNT: a channel counter increments when event detected and ch_enable[k]=1.
    - timer increments each cycle
    - exit to LATCH when (win_len!=0 and timer==win_len-1) or stop=1
    - window length is therefore exactly win_len cycles of counting
  - LATCH: one cycle. Copy counters and overflow flags to the snapshot outputs; done=1; busy=0; next state IDLE. Events in this cycle are not counted.
- Events detected in the final COUNT cycle are included in the snapshot.
- Saturation: a counter at all-ones stays at all-ones and sets its sticky overflow flag. It does not wrap.
- start while in COUNT restarts the window: counters and timer cleared, no latch, done unchanged. start in LATCH is ignored.
- start and stop in the same IDLE cycle: start wins. stop in IDLE is ignored.
- win_len is sampled at start and held internally for the window.
- cnt_snapshot and ovf_snapshot change only in LATCH, so they are always coherent across channels.

Optional Feature:
Macro EVENT_TIMESTAMP_EN.
- Defined: adds output last_ts (NUM_CH*WIN_WIDTH).
  - holds the window timer value at each channel's last counted event
  - cleared at start; latched with the snapshot; 0 if no event occurred
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset mid-window: start, then 3 toggles, then S_AXI_ARESETN=0 for 1 cycle -> busy=0, done=0, cnt_snapshot=0, no latch.
- Basic window: NUM_CH=2, win_len=100, edge_mode=0, 10 toggles on ch0, 4 on ch1 inside the window -> busy high exactly 100 cycles, done=1, ch0=10, ch1=4, ovf_snapshot=0.
- Edge mode: edge_mode=1, 10 toggles on ch0 -> ch0=5.
- Per-channel enable: ch_enable=2'b01, 6 toggles on ch1 -> ch1=0 in the snapshot, yet 6 event_pulse[1] pulses are seen.
- Saturation: CNT_WIDTH=8, 300 events, win_len=0, then stop -> ch0=255, ovf_snapshot[0]=1, latch one cycle after stop.
- Boundary/restart:
  - event in the last COUNT cycle -> counted
  - event in the LATCH cycle -> not counted
  - start in COUNT after 7 events -> counters restart from 0 with no latch
  - with EVENT_TIMESTAMP_EN, an event at timer=42 -> last_ts=42.
